// File: rtl/pim_dma_pkg.sv
// pim_dma_pkg: shared FSM state type, register offsets and status bit
// positions for the PIM DMA loader.
package pim_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WAIT,
    WRITE,
    FIN
  } dma_state_t;

  // Register word offsets inside the 16-byte window (riscv_addr[3:2]).
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits.
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  // STATUS read bits.
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  function automatic logic [31:0] status_word(input logic err,
                                              input logic done,
                                              input logic busy);
    logic [31:0] w;
    w            = '0;
    w[STAT_BUSY] = busy;
    w[STAT_DONE] = done;
    w[STAT_ERR]  = err;
    return w;
  endfunction

endpackage

// File: rtl/pim_dma_regs.sv
// pim_dma_regs: CPU-visible register window of the PIM DMA loader.
// Decodes the 16-byte window, holds SRC/DST/LEN and the sticky DONE/ERR
// flags, produces the start pulse and the registered read data.
module pim_dma_regs
  import pim_dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          AW        = 10
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic [31:0]   riscv_addr,
  input  logic [31:0]   riscv_wdata,
  input  logic [3:0]    riscv_wmask,
  input  logic          riscv_rstrb,
  output logic [31:0]   riscv_rdata,
  input  logic          busy,
  input  logic          done_set,
  input  logic          err_set,
  output logic [AW-1:0] src_cfg,
  output logic [AW-1:0] dst_cfg,
  output logic [AW:0]   len_cfg,
  output logic          start
);

  logic          sel;
  logic          wr_en;
  logic [1:0]    word_sel;
  logic          cfg_wr;
  logic          ctrl_wr;
  logic          clear;
  logic [AW-1:0] src_reg;
  logic [AW-1:0] dst_reg;
  logic [AW:0]   len_reg;
  logic          done_reg;
  logic          done_next;
  logic          err_reg;
  logic          err_next;
  logic [31:0]   rdata_reg;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  // Only whole-word writes are honoured; byte lanes and sub-word addresses
  // carry no meaning for these registers.
  assign sel         = (riscv_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en       = sel && (riscv_wmask == 4'hF);
  assign word_sel    = riscv_addr[3:2];
  assign cfg_wr      = wr_en && !busy;
  assign ctrl_wr     = wr_en && (word_sel == REG_CTRL);
  assign clear       = ctrl_wr && riscv_wdata[CTRL_CLEAR];
  assign start       = ctrl_wr && riscv_wdata[CTRL_START] && !busy;
  assign unused_bits = ^{riscv_addr[1:0], riscv_wdata[31:AW+1]};

  // Copy parameters; frozen while a copy owns the RAM ports.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
    end else if (cfg_wr) begin
      if (word_sel == REG_SRC) src_reg <= riscv_wdata[AW-1:0];
      if (word_sel == REG_DST) dst_reg <= riscv_wdata[AW-1:0];
      if (word_sel == REG_LEN) len_reg <= riscv_wdata[AW:0];
    end
  end

  // Sticky flags: a clear request applies first, an engine event overrides it.
  always_comb begin
    done_next = done_reg;
    err_next  = err_reg;
    if (clear) begin
      done_next = 1'b0;
      err_next  = 1'b0;
    end
    if (done_set) done_next = 1'b1;
    if (err_set)  err_next  = 1'b1;
  end

  // Status flag registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      done_reg <= done_next;
      err_reg  <= err_next;
    end
  end

  // Read mux; anything other than a selected read returns zero.
  always_comb begin
    rdata_next = '0;
    if (riscv_rstrb && sel) begin
      case (word_sel)
        REG_SRC:  rdata_next = 32'(src_reg);
        REG_DST:  rdata_next = 32'(dst_reg);
        REG_LEN:  rdata_next = 32'(len_reg);
        default:  rdata_next = status_word(err_reg, done_reg, busy);
      endcase
    end
  end

  // Read data is registered and valid the cycle after the strobe.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rdata_reg <= '0;
    else       rdata_reg <= rdata_next;
  end

  assign riscv_rdata = rdata_reg;
  assign src_cfg     = src_reg;
  assign dst_cfg     = dst_reg;
  assign len_cfg     = len_reg;

endmodule

// File: rtl/pim_dma_loader.sv
// pim_dma_loader: memory-mapped word copy engine RAM1 -> RAM2 used to load
// the PIM memory before the PIM core runs. One word is moved every RD_LAT+2
// cycles: READ issues the read, WAIT covers the RAM latency and captures the
// word on its last cycle, WRITE stores it.
// Optional feature: define PIM_DMA_RST_EN to add the pim_rstN output that
// keeps the PIM core in reset until a load has completed successfully.
module pim_dma_loader
  import pim_dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          AW        = 10,
  parameter int          RD_LAT    = 2
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic [31:0]   riscv_addr,
  input  logic [31:0]   riscv_wdata,
  input  logic [3:0]    riscv_wmask,
  input  logic          riscv_rstrb,
  output logic [31:0]   riscv_rdata,
  output logic          busy,
  output logic [AW-1:0] src_addr,
  output logic          src_rden,
  input  logic [31:0]   src_rdata,
  output logic [AW-1:0] dst_addr,
  output logic [31:0]   dst_wdata,
  output logic          dst_wen,
  output logic [3:0]    dst_byteena
`ifdef PIM_DMA_RST_EN
  ,
  output logic          pim_rstN
`endif
);

  localparam logic [1:0]  WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [AW+1:0] RAM_LIMIT = {2'b01, {AW{1'b0}}};

  dma_state_t    state_reg;
  dma_state_t    state_next;
  logic [AW:0]   idx_reg;
  logic [AW:0]   idx_plus;
  logic [1:0]    wait_cnt_reg;
  logic [31:0]   data_reg;
  logic [AW-1:0] src_cfg;
  logic [AW-1:0] dst_cfg;
  logic [AW:0]   len_cfg;
  logic          start;
  logic          done_set;
  logic          err_set;
  logic          len_zero;
  logic          range_err;
  logic [AW+1:0] src_end;
  logic [AW+1:0] dst_end;

  pim_dma_regs #(
    .BASE_ADDR (BASE_ADDR),
    .AW        (AW)
  ) u_regs (
    .clk         (clk),
    .rstN        (rstN),
    .riscv_addr  (riscv_addr),
    .riscv_wdata (riscv_wdata),
    .riscv_wmask (riscv_wmask),
    .riscv_rstrb (riscv_rstrb),
    .riscv_rdata (riscv_rdata),
    .busy        (busy),
    .done_set    (done_set),
    .err_set     (err_set),
    .src_cfg     (src_cfg),
    .dst_cfg     (dst_cfg),
    .len_cfg     (len_cfg),
    .start       (start)
  );

  // Range check is done with two spare bits so SRC+LEN can never wrap.
  assign src_end   = {2'b00, src_cfg} + {1'b0, len_cfg};
  assign dst_end   = {2'b00, dst_cfg} + {1'b0, len_cfg};
  assign range_err = (src_end > RAM_LIMIT) || (dst_end > RAM_LIMIT);
  assign len_zero  = (len_cfg == '0);
  assign idx_plus  = idx_reg + (AW+1)'(1);

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = CHECK;
      CHECK: begin
        if (len_zero)       state_next = FIN;
        else if (range_err) state_next = IDLE;
        else                state_next = READ;
      end
      READ:  state_next = WAIT;
      WAIT:  if (wait_cnt_reg == WAIT_LAST) state_next = WRITE;
      WRITE: state_next = (idx_plus == len_cfg) ? FIN : READ;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; RAM ports are idle (all zero) outside their active state.
  always_comb begin
    busy      = 1'b1;
    src_rden  = 1'b0;
    src_addr  = '0;
    dst_wen   = 1'b0;
    dst_addr  = '0;
    dst_wdata = '0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state_reg)
      IDLE:  busy = 1'b0;
      CHECK: err_set = !len_zero && range_err;
      READ: begin
        src_rden = 1'b1;
        src_addr = src_cfg + idx_reg[AW-1:0];
      end
      WRITE: begin
        dst_wen   = 1'b1;
        dst_addr  = dst_cfg + idx_reg[AW-1:0];
        dst_wdata = data_reg;
      end
      FIN:   done_set = 1'b1;
      default: ;
    endcase
  end

  // All byte lanes are written together.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byteena
      assign dst_byteena[gi] = dst_wen;
    end
  endgenerate

  // Datapath: word index, latency counter and captured read word.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      data_reg     <= '0;
    end else begin
      if (state_reg == CHECK) idx_reg <= '0;
      if (state_reg == WRITE) idx_reg <= idx_plus;
      if (state_reg == READ)  wait_cnt_reg <= '0;
      if (state_reg == WAIT)  wait_cnt_reg <= wait_cnt_reg + 2'd1;
      if (state_reg == WAIT && wait_cnt_reg == WAIT_LAST) data_reg <= src_rdata;
    end
  end

`ifdef PIM_DMA_RST_EN
  logic pim_rst_reg;

  // PIM core stays in reset from any start until that load finishes cleanly.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                  pim_rst_reg <= 1'b0;
    else if (start)             pim_rst_reg <= 1'b0;
    else if (state_reg == FIN)  pim_rst_reg <= 1'b1;
  end

  assign pim_rstN = pim_rst_reg;
`endif

endmodule

// File: tb/tb_pim_dma_loader.sv
// tb_pim_dma_loader: directed self-checking bench for pim_dma_loader with a
// behavioural RAM1 (RD_LAT read pipeline) and RAM2, and a write scoreboard.
module tb_pim_dma_loader;

  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam int          AW     = 10;
  localparam int          RD_LAT = 2;

  logic          clk;
  logic          rstN;
  logic [31:0]   riscv_addr;
  logic [31:0]   riscv_wdata;
  logic [3:0]    riscv_wmask;
  logic          riscv_rstrb;
  logic [31:0]   riscv_rdata;
  logic          busy;
  logic [AW-1:0] src_addr;
  logic          src_rden;
  logic [31:0]   src_rdata;
  logic [AW-1:0] dst_addr;
  logic [31:0]   dst_wdata;
  logic          dst_wen;
  logic [3:0]    dst_byteena;
`ifdef PIM_DMA_RST_EN
  logic          pim_rstN;
`endif

  pim_dma_loader #(
    .BASE_ADDR (BASE),
    .AW        (AW),
    .RD_LAT    (RD_LAT)
  ) dut (
`ifdef PIM_DMA_RST_EN
    .pim_rstN    (pim_rstN),
`endif
    .clk         (clk),
    .rstN        (rstN),
    .riscv_addr  (riscv_addr),
    .riscv_wdata (riscv_wdata),
    .riscv_wmask (riscv_wmask),
    .riscv_rstrb (riscv_rstrb),
    .riscv_rdata (riscv_rdata),
    .busy        (busy),
    .src_addr    (src_addr),
    .src_rden    (src_rden),
    .src_rdata   (src_rdata),
    .dst_addr    (dst_addr),
    .dst_wdata   (dst_wdata),
    .dst_wen     (dst_wen),
    .dst_byteena (dst_byteena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM models ----------------
  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  logic [31:0] rd_pipe [RD_LAT];
  logic [RD_LAT-1:0] rd_vld;

  always @(posedge clk) begin
    rd_pipe[0] <= mem1[src_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (!rstN) rd_vld <= '0;
    else       rd_vld <= {rd_vld[RD_LAT-2:0], src_rden};
  end
  // Data is only valid for exactly one cycle; any other sample sees a marker.
  assign src_rdata = rd_vld[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dst_wen && dst_byteena[b]) mem2[dst_addr][8*b +: 8] <= dst_wdata[8*b +: 8];
  end

  // ---------------- scoreboard / monitors ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  check_cnt = 0;
  int  pass_cnt  = 0;
  int  busy_cnt  = 0;
  int  rden_cnt  = 0;
  int  wen_cnt   = 0;
  int  busy_base, rden_base, wen_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      if (busy)     busy_cnt++;
      if (src_rden) rden_cnt++;
      if (dst_wen) begin
        wen_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_wr", {31'b0, dst_wen}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(dst_addr), 32'(mon_e.addr));
          check("wr_data", dst_wdata, mon_e.data);
          check("wr_be", 32'(dst_byteena), 32'hF);
          $display("write addr=%h data=%h", dst_addr, dst_wdata);
        end
      end
    end
  end

  // ---------------- CPU bus tasks ----------------
  task automatic cpu_write_m(input logic [3:0] off, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    riscv_addr  = BASE | 32'(off);
    riscv_wdata = data;
    riscv_wmask = mask;
    @(negedge clk);
    riscv_wmask = 4'h0;
    $display("cpu write off=%h data=%h mask=%h", off, data, mask);
  endtask

  task automatic cpu_write(input logic [3:0] off, input logic [31:0] data);
    cpu_write_m(off, data, 4'hF);
  endtask

  task automatic read_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
    @(negedge clk);
    riscv_addr  = BASE | 32'(off);
    riscv_rstrb = 1'b1;
    @(negedge clk);
    riscv_rstrb = 1'b0;
    $display("cpu read off=%h data=%h", off, riscv_rdata);
    check(tag, riscv_rdata, exp);
  endtask

  task automatic configure(input int src, input int dst, input int len, input bit push);
    wr_t w;
    cpu_write(4'h0, 32'(src));
    cpu_write(4'h4, 32'(dst));
    cpu_write(4'h8, 32'(len));
    if (push) begin
      for (int k = 0; k < len; k++) begin
        w.addr = AW'(dst + k);
        w.data = mem1[src + k];
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic start_copy();
    busy_base = busy_cnt;
    rden_base = rden_cnt;
    wen_base  = wen_cnt;
    cpu_write(4'hC, 32'h3);   // clear flags then start
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 500 && busy; n++) @(negedge clk);
    #1;
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstN        = 1'b0;
    riscv_addr  = '0;
    riscv_wdata = '0;
    riscv_wmask = '0;
    riscv_rstrb = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 32'h5A00_0000 | 32'(i);
      mem2[i] <= 32'h0;
    end
    for (int k = 0; k < 4; k++) mem1[16 + k] = 32'hA0 + 32'(k);

    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rden", {31'b0, src_rden}, 32'd0);
    check("rst_wen", {31'b0, dst_wen}, 32'd0);
    check("rst_be", 32'(dst_byteena), 32'd0);
    check("rst_rdata", riscv_rdata, 32'd0);
`ifdef PIM_DMA_RST_EN
    check("rst_pim", {31'b0, pim_rstN}, 32'd0);
`endif
    rstN = 1'b1;
    read_check("rst_src", 4'h0, 32'd0);
    read_check("rst_status", 4'hC, 32'd0);
    @(negedge clk);
    check("rdata_idle_zero", riscv_rdata, 32'd0);

    // LEN=1 at the very top word of both RAMs (exactly in range).
    configure(32'h3FF, 32'h3FF, 1, 1'b1);
    start_copy();
    wait_idle("len1_idle");
    check("len1_busy_cycles", 32'(busy_cnt - busy_base), 32'(1 * (RD_LAT + 2) + 2));
    check("len1_mem2", mem2[1023], 32'h5A00_03FF);
    read_check("len1_status", 4'hC, 32'h2);
`ifdef PIM_DMA_RST_EN
    check("pim_after_fin", {31'b0, pim_rstN}, 32'd1);
`endif

    // Main copy: SRC=0x10 DST=0x0 LEN=4.
    configure(32'h10, 32'h0, 4, 1'b1);
    read_check("src_readback", 4'h0, 32'h10);
    read_check("len_readback", 4'h8, 32'h4);
    start_copy();
`ifdef PIM_DMA_RST_EN
    check("pim_low_on_start", {31'b0, pim_rstN}, 32'd0);
`endif
    wait_idle("copy4_idle");
    check("copy4_busy_cycles", 32'(busy_cnt - busy_base), 32'(4 * (RD_LAT + 2) + 2));
    check("copy4_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 4; k++) check("copy4_mem2", mem2[k], 32'hA0 + 32'(k));
    read_check("copy4_status", 4'hC, 32'h2);

    // Partial-mask write is ignored.
    cpu_write_m(4'h0, 32'h77, 4'h3);
    read_check("partial_mask_src", 4'h0, 32'h10);

    // LEN=0: DONE after CHECK+FIN, no RAM access.
    cpu_write(4'h8, 32'h0);
    start_copy();
    wait_idle("len0_idle");
    check("len0_busy_cycles", 32'(busy_cnt - busy_base), 32'd2);
    check("len0_no_wen", 32'(wen_cnt - wen_base), 32'd0);
    check("len0_no_rden", 32'(rden_cnt - rden_base), 32'd0);
    read_check("len0_status", 4'hC, 32'h2);

    // Source overrun: ERR, no access, then clear.
    configure(32'h3FE, 32'h0, 4, 1'b0);
    start_copy();
    wait_idle("srcerr_idle");
    check("srcerr_busy_cycles", 32'(busy_cnt - busy_base), 32'd1);
    check("srcerr_no_rden", 32'(rden_cnt - rden_base), 32'd0);
    check("srcerr_no_wen", 32'(wen_cnt - wen_base), 32'd0);
    read_check("srcerr_status", 4'hC, 32'h4);
    cpu_write(4'hC, 32'h2);
    read_check("clear_status", 4'hC, 32'h0);

    // Destination overrun by one word.
    configure(32'h0, 32'h3FD, 4, 1'b0);
    start_copy();
    wait_idle("dsterr_idle");
    check("dsterr_no_wen", 32'(wen_cnt - wen_base), 32'd0);
    read_check("dsterr_status", 4'hC, 32'h4);

    // Destination ends exactly at the last word: legal.
    configure(32'h0, 32'h3FC, 4, 1'b1);
    start_copy();
    wait_idle("dstedge_idle");
    check("dstedge_wen", 32'(wen_cnt - wen_base), 32'd4);
    read_check("dstedge_status", 4'hC, 32'h2);

    // Writes and a second start while busy are ignored.
    configure(32'h20, 32'h40, 3, 1'b1);
    start_copy();
    cpu_write(4'h0, 32'h55);
    cpu_write(4'h8, 32'h7);
    cpu_write(4'hC, 32'h1);
    wait_idle("busyign_idle");
    check("busyign_busy_cycles", 32'(busy_cnt - busy_base), 32'(3 * (RD_LAT + 2) + 2));
    check("busyign_queue_empty", 32'(exp_q.size()), 32'd0);
    read_check("busyign_src", 4'h0, 32'h20);
    read_check("busyign_len", 4'h8, 32'h3);

    // Reset in the middle of an 8-word copy.
    configure(32'h100, 32'h200, 8, 1'b1);
    start_copy();
    for (int n = 0; n < 200 && (wen_cnt - wen_base) < 2; n++) begin
      @(negedge clk);
      #1;
    end
    check("midrst_two_words", 32'(wen_cnt - wen_base), 32'd2);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_rden", {31'b0, src_rden}, 32'd0);
    check("midrst_wen", {31'b0, dst_wen}, 32'd0);
    check("midrst_be", 32'(dst_byteena), 32'd0);
    check("midrst_rdata", riscv_rdata, 32'd0);
`ifdef PIM_DMA_RST_EN
    check("midrst_pim", {31'b0, pim_rstN}, 32'd0);
`endif
    exp_q.delete();
    check("midrst_mem2_0", mem2[512], 32'h5A00_0100);
    check("midrst_mem2_1", mem2[513], 32'h5A00_0101);
    check("midrst_mem2_2", mem2[514], 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    read_check("midrst_status", 4'hC, 32'h0);
    read_check("midrst_src", 4'h0, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Global time bound in case a wait misbehaves.
  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
